// File: rtl/aes_dec_pkg.sv
// Shared constants, types and helpers for the AES-128 inverse-cipher datapath.
package aes_dec_pkg;

  localparam int NR        = 10;
  localparam int KEY_WORDS = 4 * (NR + 1);

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [3:0]   round_t;

  localparam round_t LAST_ROUND = round_t'(NR);

  // InvMixColumns is skipped for the first and last inverse rounds.
  function automatic logic is_mix_round(input round_t r);
    return (r >= round_t'(1)) && (r <= LAST_ROUND - round_t'(1));
  endfunction

endpackage

// File: rtl/round_key_store.sv
// Serially loaded store of the expanded round keys with a 128-bit read port
// selected by round index.
module round_key_store
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         wr_en,
  input  logic [31:0]  wr_word,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         keys_ready
);

  localparam int CW = $clog2(KEY_WORDS + 1);

  word_t         mem [KEY_WORDS];
  logic [CW-1:0] wc_reg;
  logic          can_write;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] rd_base;

  // A restart pulse coinciding with a write lands that word at index 0.
  assign can_write = wr_en && (load_start || (wc_reg < CW'(KEY_WORDS)));
  assign wr_idx    = load_start ? '0 : wc_reg;

  always_ff @(posedge clk) begin
    if (can_write) begin
      mem[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_reg     <= '0;
      keys_ready <= 1'b0;
    end else if (load_start) begin
      wc_reg     <= wr_en ? CW'(1) : '0;
      keys_ready <= 1'b0;
    end else if (can_write) begin
      wc_reg <= wc_reg + CW'(1);
      if (wc_reg == CW'(KEY_WORDS - 1)) begin
        keys_ready <= 1'b1;
      end
    end
  end

  // Out-of-range rounds read round 0; the stage bypasses the key for them anyway.
  assign rd_base = (rd_round > LAST_ROUND) ? '0 : CW'({rd_round, 2'b00});

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign rd_key[127-32*gi -: 32] = mem[rd_base + CW'(gi)];
    end
  endgenerate

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of the AES-128 inverse cipher with valid/ready
// handshake and InvMixColumns enable for the downstream stage.
module inv_add_round_key_stage
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load_start,
  input  logic         key_wr_en,
  input  logic [31:0]  key_wr_word,
  output logic         keys_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix_en,
  output logic         out_round_err
);

  state_t round_key;
  logic   accept;
  logic   round_err;

  round_key_store u_key_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (key_load_start),
    .wr_en      (key_wr_en),
    .wr_word    (key_wr_word),
    .rd_round   (in_round),
    .rd_key     (round_key),
    .keys_ready (keys_ready)
  );

  assign in_ready  = keys_ready && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign round_err = in_round > LAST_ROUND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_state     <= '0;
      out_round     <= '0;
      out_mix_en    <= 1'b0;
      out_round_err <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_state     <= round_err ? in_state : (in_state ^ round_key);
      out_round     <= in_round;
      out_mix_en    <= is_mix_round(in_round);
      out_round_err <= round_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed bench for inv_add_round_key_stage using the AES-128 key schedule of
// key 000102030405060708090a0b0c0d0e0f.
module tb_inv_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load_start = 1'b0;
  logic         key_wr_en = 1'b0;
  logic [31:0]  key_wr_word = '0;
  logic         keys_ready;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [3:0]   in_round = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_mix_en;
  logic         out_round_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] w [44];

  inv_add_round_key_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_load_start (key_load_start),
    .key_wr_en      (key_wr_en),
    .key_wr_word    (key_wr_word),
    .keys_ready     (keys_ready),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_state       (in_state),
    .in_round       (in_round),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_state      (out_state),
    .out_round      (out_round),
    .out_mix_en     (out_mix_en),
    .out_round_err  (out_round_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: x^254 in GF(2^8) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base;
    inv = 8'h01; base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] rkey(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic expand_key();
    logic [31:0] t;
    logic [7:0]  rcon;
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL reset_keys_ready got %b want 0", keys_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state got %h want 0", out_state); end
    checks++; if (out_round !== 4'h0) begin errors++; $display("FAIL reset_out_round got %h want 0", out_round); end
    checks++; if ({out_mix_en, out_round_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {out_mix_en, out_round_err}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    $display("reset: keys_ready=%b out_valid=%b in_ready=%b", keys_ready, out_valid, in_ready);
    rst_n = 1'b1;
  endtask

  task automatic test_key_load();
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (i == 43) begin
        checks++; if (keys_ready !== 1'b0) begin errors++; $display("FAIL key_ready_early got %b want 0", keys_ready); end
      end
      key_wr_en = 1'b1;
      key_wr_word = w[i];
    end
    @(negedge clk);
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL key_ready_after_44 got %b want 1", keys_ready); end
    key_wr_word = 32'hdeadbeef;
    @(negedge clk);
    key_wr_en = 1'b0;
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL key_ready_after_45 got %b want 1", keys_ready); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL key_in_ready got %b want 1", in_ready); end
    $display("key_load: 44 words + 1 extra, keys_ready=%b", keys_ready);
  endtask

  task automatic test_round10();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_state = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; in_round = 4'd10;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r10_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL r10_out_valid got %b want 1", out_valid); end
    checks++; if (out_state !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin errors++; $display("FAIL r10_state got %h want 7ad5fda789ef4e272bca100b3d9ff59f", out_state); end
    checks++; if (out_round !== 4'd10) begin errors++; $display("FAIL r10_round got %0d want 10", out_round); end
    checks++; if ({out_mix_en, out_round_err} !== 2'b00) begin errors++; $display("FAIL r10_flags got %b want 00", {out_mix_en, out_round_err}); end
    $display("round10: out_state=%h mix=%b err=%b", out_state, out_mix_en, out_round_err);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL r10_drain got %b want 0", out_valid); end
  endtask

  task automatic test_rounds();
    int          rounds [4] = '{0, 5, 1, 9};
    logic        mixes  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [127:0] exp_state;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_state = '0; in_round = 4'(rounds[k]);
      @(negedge clk);
      in_valid = 1'b0;
      exp_state = (rounds[k] == 0) ? 128'h000102030405060708090a0b0c0d0e0f : rkey(rounds[k]);
      checks++; if (out_state !== exp_state) begin errors++; $display("FAIL rk%0d_state got %h want %h", rounds[k], out_state, exp_state); end
      checks++; if (out_mix_en !== mixes[k]) begin errors++; $display("FAIL rk%0d_mix got %b want %b", rounds[k], out_mix_en, mixes[k]); end
      checks++; if (out_round_err !== 1'b0) begin errors++; $display("FAIL rk%0d_err got %b want 0", rounds[k], out_round_err); end
      $display("round%0d: out_state=%h mix=%b", rounds[k], out_state, out_mix_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sa, sb, sc;
    sa = 128'h00112233445566778899aabbccddeeff;
    sb = 128'hffeeddccbbaa99887766554433221100;
    sc = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_state = sa; in_round = 4'd1;
    @(negedge clk);
    in_state = sb; in_round = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_state !== (sa ^ rkey(1))) begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", k, out_valid, out_state, sa ^ rkey(1)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", k, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_state !== (sb ^ rkey(2)) || out_round !== 4'd2) begin errors++; $display("FAIL bp_second got %h/%0d want %h/2", out_state, out_round, sb ^ rkey(2)); end
    in_state = sc; in_round = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_state !== (sc ^ rkey(3))) begin errors++; $display("FAIL bp_third got %b/%h want 1/%h", out_valid, out_state, sc ^ rkey(3)); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    $display("back_to_back: three results delivered after 4 stalled cycles");
  endtask

  task automatic test_error_round();
    int rounds [3] = '{12, 11, 15};
    logic [127:0] s;
    s = 128'hcafef00d0badc0de1234567890abcdef;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_state = s; in_round = 4'(rounds[k]);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_state !== s) begin errors++; $display("FAIL err%0d_state got %h want %h", rounds[k], out_state, s); end
      checks++; if ({out_round_err, out_mix_en} !== 2'b10) begin errors++; $display("FAIL err%0d_flags got %b want 10", rounds[k], {out_round_err, out_mix_en}); end
      checks++; if (out_round !== 4'(rounds[k])) begin errors++; $display("FAIL err%0d_round got %0d want %0d", rounds[k], out_round, rounds[k]); end
      $display("error_round%0d: out_state=%h err=%b", rounds[k], out_state, out_round_err);
    end
  endtask

  task automatic test_reload_reset();
    logic [127:0] p, exp_p;
    p = 128'h3243f6a8885a308d313198a2e0370734;
    exp_p = p ^ rkey(4);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_state = p; in_round = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    key_load_start = 1'b1; key_wr_en = 1'b1; key_wr_word = w[0];
    @(negedge clk);
    key_load_start = 1'b0;
    checks++; if (keys_ready !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reload_ready got %b/%b want 0/0", keys_ready, in_ready); end
    checks++; if (out_valid !== 1'b1 || out_state !== exp_p) begin errors++; $display("FAIL reload_pending got %b/%h want 1/%h", out_valid, out_state, exp_p); end
    for (int i = 1; i < 44; i++) begin
      key_wr_word = w[i];
      @(negedge clk);
    end
    key_wr_en = 1'b0;
    checks++; if (keys_ready !== 1'b1) begin errors++; $display("FAIL reload_done got %b want 1", keys_ready); end
    checks++; if (out_state !== exp_p || out_round !== 4'd4) begin errors++; $display("FAIL reload_held got %h/%0d want %h/4", out_state, out_round, exp_p); end
    out_ready = 1'b1; in_valid = 1'b1; in_state = '0; in_round = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_state !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL reload_word0 got %h want 000102030405060708090a0b0c0d0e0f", out_state); end
    $display("reload: pending kept, keys_ready=%b, word0 ok", keys_ready);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_state = p; in_round = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pending got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || keys_ready !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_reset got %b/%b/%b want 0/0/0", out_valid, keys_ready, in_ready); end
    checks++; if (out_state !== 128'h0 || out_round !== 4'h0) begin errors++; $display("FAIL async_reset_data got %h/%0d want 0/0", out_state, out_round); end
    $display("reset_mid_stream: out_valid=%b keys_ready=%b", out_valid, keys_ready);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    expand_key();
    test_reset();
    test_key_load();
    test_round10();
    test_rounds();
    test_back_to_back();
    test_error_round();
    test_reload_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
